key_incr_gen: RTL
=================

# key_incr_gen

Converts a raw, bouncing pushbutton into clean single-cycle `incr` pulses for the `counter` block's `incr` input. It synchronizes the asynchronous button and debounces both press and release. It emits one pulse per press, plus optional auto-repeat pulses while the button stays held. It sits directly upstream of `counter`, and its `incr` output wires straight to `counter.incr`.

## Interface

- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a press or release; must be ≥1.
- `REPEAT_DELAY`, default 64: cycles from the first pulse to the first auto-repeat pulse; 0 disables auto-repeat.
- `REPEAT_PERIOD`, default 16: cycles between successive auto-repeat pulses; must be ≥1.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `btn_raw` input, 1 bit: asynchronous button level, 1 = pressed; may bounce.
- `incr` output, 1 bit: registered, single-cycle increment pulse.
- `pressed` output, 1 bit: registered debounced button level.

## Operation

- Synchronizer: a 2-flop chain turns `btn_raw` into `btn_s`, which lags `btn_raw` by 2 edges. Only `btn_s` drives the FSM.
- Internal counters:
  - `db_cnt` is sized for `DEBOUNCE_CYCLES`.
  - `rp_cnt` is sized for max(`REPEAT_DELAY`, `REPEAT_PERIOD`), with a `first` flag.
  - Both counters saturate and never wrap.
- FSM states are IDLE, PRESS_DB, HELD and RELEASE_DB.
- IDLE:
  - `btn_s`=1 → PRESS_DB, with `db_cnt`=0.
- PRESS_DB:
  - `btn_s`=0 → IDLE, with no pulse (bounce is rejected).
  - `btn_s`=1 and `db_cnt`<D-1 → `db_cnt`++.
  - `btn_s`=1 and `db_cnt`==D-1 → HELD. `incr`=1 for that one cycle; `rp_cnt`=0 and `first`=1.
- HELD:
  - `btn_s`=0 → RELEASE_DB, with `db_cnt`=0 and no pulse. This wins over a simultaneous repeat expiry.
  - `btn_s`=1 with `REPEAT_DELAY`>0: `rp_cnt`++. When `rp_cnt` reaches `REPEAT_DELAY`-1 (if `first`=1) or `REPEAT_PERIOD`-1 (if `first`=0), emit a one-cycle `incr`, clear `rp_cnt` and clear `first`.
- RELEASE_DB:
  - `btn_s`=1 → HELD, with no pulse. `rp_cnt`=0 and `first`=1, so the repeat schedule restarts from `REPEAT_DELAY`.
  - `btn_s`=0 and `db_cnt`<D-1 → `db_cnt`++.
  - `btn_s`=0 and `db_cnt`==D-1 → IDLE.
- `pressed`=1 exactly while the FSM is in HELD or RELEASE_DB.
- `incr` is never high on two consecutive cycles when `REPEAT_PERIOD`≥2. With `REPEAT_PERIOD`=1, back-to-back pulses are legal.

## Timing

- Reset, when `reset`=1 at an edge:
  - Sync flops, `db_cnt`, `rp_cnt` → 0; `first` → 1.
  - FSM → IDLE; `incr` → 0; `pressed` → 0.
  - Reset overrides every other condition.
- Reset mid-press: after `reset` deasserts, a still-held button is treated as a new press. It goes through the full debounce and produces a fresh first pulse.
- Press latency (D = `DEBOUNCE_CYCLES`):
  - Edge 0 is the first edge sampling `btn_raw`=1, with `btn_raw` stable after that.
  - PRESS_DB is entered at edge 2.
  - `incr`=1 and `pressed`=1 after edge D+2; `incr` returns to 0 after edge D+3.
- Repeat timing (E = edge at which the first pulse asserts):
  - The first repeat asserts after edge E+`REPEAT_DELAY`.
  - Later repeats assert after edges E+`REPEAT_DELAY`+k·`REPEAT_PERIOD`, for k≥1.
- Release latency:
  - Edge r is the first edge sampling `btn_raw`=0, with `btn_raw` stable after that.
  - RELEASE_DB is entered at edge r+2; `pressed`=0 after edge r+D+2.
- Glitch rejection: a low glitch on `btn_s` shorter than D cycles during HELD keeps `pressed`=1 and produces no pulse.

## Test plan

All scenarios use D=4, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=3.

1. Hold `reset`=1 for 10 cycles with `btn_raw`=1 → `incr`=0 and `pressed`=0 on every cycle.
2. Clean press from edge 0, held 12 cycles → `incr`=1 only after edge 6; `pressed` rises after edge 6.
3. Bounce: `btn_raw`=1 for 3 cycles, then 0 → no `incr`; `pressed` stays 0; FSM back in IDLE.
4. Long hold from edge 0 for 30 cycles:
   - `incr` pulses after edges 6, 14, 17, 20, 23, 26, 29.
   - Release sampled at edge 30 → `pressed`=0 after edge 36.
5. During HELD, a 2-cycle low glitch on `btn_raw` → `pressed` stays 1, no extra pulse, and the first repeat arrives 8 cycles after return to HELD.
6. Reset and counter integration:
   - Assert `reset` for 1 cycle mid-hold with the button held → both outputs 0 after that edge.
   - A new first pulse follows 6 edges after reset deasserts.
   - Five clean presses into `counter` (`N_WIDTH`=4, up mode) → `y`=5.

Source files
------------

// File: rtl/key_incr_gen.sv
// key_incr_gen: turns a raw, bouncing pushbutton into clean single-cycle
// increment pulses, with an optional auto-repeat while the button is held.
// The button is synchronized by a two-flop chain, then a four-state FSM
// debounces both press and release and schedules the repeat pulses.
module key_incr_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic incr,
    output logic pressed
);

    // Counter widths: each counter only ever holds values up to its limit minus one.
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RP_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W    = (RP_SPAN > 1) ? $clog2(RP_SPAN) : 1;

    // Terminal counts for debounce, first repeat, later repeats and saturation.
    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);
    localparam logic [RP_W-1:0] RP_SAT      = RP_W'(RP_SPAN - 1);
    localparam bit              REPEAT_EN   = (REPEAT_DELAY > 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_RELEASE_DB
    } state_t;

    logic            r_syncMeta;
    logic            r_btnSync;
    logic            w_btnS;

    state_t          r_state;
    state_t          w_stateNext;
    logic [DB_W-1:0] r_dbCnt;
    logic [DB_W-1:0] w_dbCntNext;
    logic [RP_W-1:0] r_rpCnt;
    logic [RP_W-1:0] w_rpCntNext;
    logic            r_first;
    logic            w_firstNext;
    logic            r_incr;
    logic            w_incrNext;
    logic            r_pressed;
    logic            w_pressedNext;
    logic [RP_W-1:0] w_rpTarget;

    // Two-flop synchronizer bringing the asynchronous button into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_syncMeta <= 1'b0;
            r_btnSync  <= 1'b0;
        end else begin
            r_syncMeta <= btn_raw;
            r_btnSync  <= r_syncMeta;
        end
    end

    assign w_btnS = r_btnSync;

    // The repeat counter aims for the initial delay first, then for the period.
    assign w_rpTarget = r_first ? DELAY_LAST : PERIOD_LAST;

    // Next-state logic: debounce both edges, emit the first pulse and schedule repeats.
    always_comb begin
        w_stateNext = r_state;
        w_dbCntNext = r_dbCnt;
        w_rpCntNext = r_rpCnt;
        w_firstNext = r_first;
        w_incrNext  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_btnS) begin
                    w_stateNext = ST_PRESS_DB;
                    w_dbCntNext = '0;
                end
            end

            ST_PRESS_DB: begin
                if (!w_btnS) begin
                    w_stateNext = ST_IDLE;
                    w_dbCntNext = '0;
                end else if (r_dbCnt == DB_LAST) begin
                    w_stateNext = ST_HELD;
                    w_incrNext  = 1'b1;
                    w_rpCntNext = '0;
                    w_firstNext = 1'b1;
                end else begin
                    w_dbCntNext = r_dbCnt + DB_W'(1);
                end
            end

            ST_HELD: begin
                if (!w_btnS) begin
                    w_stateNext = ST_RELEASE_DB;
                    w_dbCntNext = '0;
                end else if (REPEAT_EN) begin
                    if (r_rpCnt == w_rpTarget) begin
                        w_incrNext  = 1'b1;
                        w_rpCntNext = '0;
                        w_firstNext = 1'b0;
                    end else if (r_rpCnt != RP_SAT) begin
                        w_rpCntNext = r_rpCnt + RP_W'(1);
                    end
                end
            end

            ST_RELEASE_DB: begin
                if (w_btnS) begin
                    w_stateNext = ST_HELD;
                    w_rpCntNext = '0;
                    w_firstNext = 1'b1;
                end else if (r_dbCnt == DB_LAST) begin
                    w_stateNext = ST_IDLE;
                    w_dbCntNext = '0;
                end else begin
                    w_dbCntNext = r_dbCnt + DB_W'(1);
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
                w_dbCntNext = '0;
                w_rpCntNext = '0;
                w_firstNext = 1'b1;
            end
        endcase
    end

    // The debounced level follows the state that is about to be entered.
    assign w_pressedNext = (w_stateNext == ST_HELD) || (w_stateNext == ST_RELEASE_DB);

    // State, counters and registered outputs; reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_dbCnt   <= '0;
            r_rpCnt   <= '0;
            r_first   <= 1'b1;
            r_incr    <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_dbCnt   <= w_dbCntNext;
            r_rpCnt   <= w_rpCntNext;
            r_first   <= w_firstNext;
            r_incr    <= w_incrNext;
            r_pressed <= w_pressedNext;
        end
    end

    assign incr    = r_incr;
    assign pressed = r_pressed;

endmodule
